logbar_peakhold: RTL and testbench

Per-band bar smoothing and peak-hold stage directly downstream of the FFT log-bar converter. Each converted 7-bit bar height (0..96) arrives with its band index on a Start/End handshake. The block applies rise-instant / fall-limited smoothing and a hold-then-fall peak marker. Results go into a per-band dual-port store that the display scanner reads independently.

---
 rtl/logbar_peakhold.sv | 209 ++++++++++++++++++++
 tb/tb_logbar_peakhold.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logbar_peakhold.sv
// logbar_peakhold
//   Per-band bar smoothing and peak-hold stage. Each bar height from the log-bar
//   converter arrives with its band index on a Start pulse. The bar rises at
//   once but falls by at most fallStep per update. A peak marker is held for
//   holdUpdates updates after every new peak, then falls by one per update,
//   never going below the bar. Results live in a per-band dual-port store:
//   port A is used by the update FSM, port B is read by the display scanner.
//
// Ports
//   Clock   in   system clock, rising edge
//   Reset   in   synchronous active-high reset; restarts the clear sweep
//   Start   in   one-cycle pulse, In/Band valid (accepted only when idle)
//   In      in   [6:0] new bar height, values above 96 clamp to 96
//   Band    in   [bwBand-1:0] band index; indices >= nBands are not written
//   Clear   in   one-cycle pulse, zero every band (accepted only when idle)
//   RdAddr  in   [bwBand-1:0] display read address
//   RdBar   out  [6:0] smoothed bar at RdAddr, one cycle latency
//   RdPeak  out  [6:0] peak marker at RdAddr, one cycle latency
//   Busy    out  update or clear sweep in progress
//   End     out  one-cycle pulse after an update is written

module logbar_peakhold #(
   parameter int nBands      = 32,
   parameter int bwBand      = 5,
   parameter int fallStep    = 3,
   parameter int holdUpdates = 12,
   parameter int bwHold      = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [6:0]        In,
   input  logic [bwBand-1:0] Band,
   input  logic              Clear,
   input  logic [bwBand-1:0] RdAddr,
   output logic [6:0]        RdBar,
   output logic [6:0]        RdPeak,
   output logic              Busy,
   output logic              End
);

   localparam int addrW    = (nBands > 1) ? $clog2(nBands) : 1;
   localparam int wordW    = 14 + bwHold;

   localparam logic [bwBand:0]   bandLimit = (bwBand + 1)'(nBands);
   localparam logic [addrW-1:0]  lastAddr  = addrW'(nBands - 1);
   localparam logic [6:0]        maxBar    = 7'd96;
   localparam logic [6:0]        fallStep7 = 7'(fallStep);
   localparam logic [bwHold-1:0] holdInit  = bwHold'(holdUpdates);

   localparam logic [2:0] CLR  = 3'd0;
   localparam logic [2:0] IDLE = 3'd1;
   localparam logic [2:0] RD   = 3'd2;
   localparam logic [2:0] CALC = 3'd3;
   localparam logic [2:0] WR   = 3'd4;

   logic [2:0]        state;
   logic [addrW-1:0]  clrAddr;
   logic [bwBand-1:0] curBand;
   logic              curBandOk;
   logic [6:0]        curIn;
   logic [wordW-1:0]  aWord;
   logic [wordW-1:0]  newWord;
   logic [wordW-1:0]  calcWord;

   logic [wordW-1:0]  store [nBands];
   logic              memWe;
   logic [addrW-1:0]  memAddr;
   logic [wordW-1:0]  memData;

   logic              acceptIdle;
   logic              takeClear;
   logic              takeStart;
   logic [6:0]        inClamped;
   logic              rdValid;

   // The cycle after a write, End is still high and the FSM is already in
   // IDLE; that cycle still counts as busy, so new commands wait one more.
   assign acceptIdle = (state == IDLE) && !End;
   assign takeClear  = acceptIdle && Clear;
   assign takeStart  = acceptIdle && Start && !Clear;
   assign Busy       = (state != IDLE) || End;
   assign inClamped  = (In > maxBar) ? maxBar : In;
   assign rdValid    = ({1'b0, RdAddr} < bandLimit);

   // ---------------------------------------------------------------- FSM
   // NOTE: every register in an always_ff block is assigned with <= so all
   // flops update together from the values present before the edge.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= CLR;
         clrAddr <= '0;
         End     <= 1'b0;
      end else begin
         End <= 1'b0;
         case (state)
            CLR: begin
               if (clrAddr == lastAddr) state <= IDLE;
               else                     clrAddr <= clrAddr + 1'b1;
            end
            IDLE: begin
               if (takeClear) begin
                  state   <= CLR;
                  clrAddr <= '0;
               end else if (takeStart) begin
                  state <= RD;
               end
            end
            RD:   state <= CALC;
            CALC: state <= WR;
            WR: begin
               End   <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state   <= CLR;
               clrAddr <= '0;
            end
         endcase
      end
   end

   // Datapath registers carry no reset: they are always loaded before use.
   always_ff @(posedge Clock) begin
      if (takeStart) begin
         curIn     <= inClamped;
         curBand   <= Band;
         curBandOk <= ({1'b0, Band} < bandLimit);
      end
      if (state == CALC) newWord <= calcWord;
   end

   // ---------------------------------------------------- update arithmetic
   logic [6:0]        storedBar;
   logic [6:0]        storedPeak;
   logic [bwHold-1:0] storedHold;
   logic [6:0]        barNext;
   logic [6:0]        peakNext;
   logic [6:0]        peakDec;
   logic [bwHold-1:0] holdNext;

   // NOTE: each always_comb output receives a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      storedBar  = aWord[wordW-1 -: 7];
      storedPeak = aWord[bwHold+6 -: 7];
      storedHold = aWord[bwHold-1:0];
      barNext    = curIn;
      peakNext   = storedPeak;
      holdNext   = storedHold;
      peakDec    = storedPeak - 7'd1;

      // Rise instantly; fall by at most fallStep. Subtractions only happen
      // when the minuend is the larger operand.
      if (curIn < storedBar && (storedBar - curIn) > fallStep7)
         barNext = storedBar - fallStep7;

      if (barNext >= storedPeak) begin
         peakNext = barNext;
         holdNext = holdInit;
      end else if (storedHold != '0) begin
         holdNext = storedHold - 1'b1;
      end else begin
         // storedPeak > barNext >= 0 here, so peakDec cannot wrap.
         peakNext = (peakDec > barNext) ? peakDec : barNext;
         holdNext = '0;
      end

      calcWord = {barNext, peakNext, holdNext};
   end

   // ------------------------------------------------------- band store
   always_comb begin
      memWe   = 1'b0;
      memAddr = clrAddr;
      memData = '0;
      if (!Reset) begin
         if (state == CLR) begin
            memWe = 1'b1;
         end else if (state == WR && curBandOk) begin
            memWe   = 1'b1;
            memAddr = curBand[addrW-1:0];
            memData = newWord;
         end
      end
   end

   // NOTE: the store array has no reset so it maps onto block RAM; it is
   // zeroed by the CLR sweep instead, which every reset starts.
   always_ff @(posedge Clock) begin
      if (memWe) store[memAddr] <= memData;
      if (takeStart) aWord <= store[Band[addrW-1:0]];
   end

   // Display port: read-before-write, so a same-address write returns old data.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         RdBar  <= '0;
         RdPeak <= '0;
      end else if (rdValid) begin
         RdBar  <= store[RdAddr[addrW-1:0]][wordW-1 -: 7];
         RdPeak <= store[RdAddr[addrW-1:0]][bwHold+6 -: 7];
      end else begin
         RdBar  <= '0;
         RdPeak <= '0;
      end
   end

endmodule

// File: tb/tb_logbar_peakhold.sv
// tb_logbar_peakhold
//   Self-checking bench for logbar_peakhold. The DUT is built with a 6-bit
//   band index so out-of-range bands (>= 32) can be driven. A per-band model
//   of bar/peak/hold is updated from the smoothing rules directly.

module tb_logbar_peakhold;

   localparam int NB = 32;

   logic       Clock;
   logic       Reset;
   logic       Start;
   logic [6:0] In;
   logic [5:0] Band;
   logic       Clear;
   logic [5:0] RdAddr;
   logic [6:0] RdBar;
   logic [6:0] RdPeak;
   logic       Busy;
   logic       End;

   int tests;
   int fails;

   int mBar  [NB];
   int mPeak [NB];
   int mHold [NB];

   logbar_peakhold #(
      .nBands(32), .bwBand(6), .fallStep(3), .holdUpdates(12), .bwHold(4)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .In(In), .Band(Band),
      .Clear(Clear), .RdAddr(RdAddr), .RdBar(RdBar), .RdPeak(RdPeak),
      .Busy(Busy), .End(End)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic void model_clear();
      for (int i = 0; i < NB; i++) begin
         mBar[i] = 0; mPeak[i] = 0; mHold[i] = 0;
      end
   endfunction

   function automatic void model_update(input int band, input int val);
      int x, b, nb;
      if (band >= NB) return;
      x  = (val > 96) ? 96 : val;
      b  = mBar[band];
      nb = (x >= b) ? x : ((b - 3 > x) ? b - 3 : x);
      mBar[band] = nb;
      if (nb >= mPeak[band]) begin
         mPeak[band] = nb;
         mHold[band] = 12;
      end else if (mHold[band] > 0) begin
         mHold[band] = mHold[band] - 1;
      end else begin
         mPeak[band] = (mPeak[band] - 1 > nb) ? mPeak[band] - 1 : nb;
      end
   endfunction

   // Full handshake; ok=0 if End/Busy deviate from the 4-cycle timing.
   task automatic do_update(input int band, input int val, output bit ok);
      ok = 1'b1;
      Band = 6'(band); In = 7'(val); Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (End !== (k == 4)) ok = 1'b0;
         if (Busy !== (k <= 4)) ok = 1'b0;
         if (k < 5) tick();
      end
      model_update(band, val);
   endtask

   task automatic read_band(input int a, output logic [6:0] bar, output logic [6:0] peak);
      RdAddr = 6'(a);
      tick();
      bar  = RdBar;
      peak = RdPeak;
   endtask

   // Counts Busy cycles from now until Busy drops, bounded.
   task automatic measure_sweep(output int cycles, output bit end_seen);
      cycles = 0; end_seen = 1'b0;
      while (Busy === 1'b1 && cycles < 200) begin
         cycles++;
         if (End === 1'b1) end_seen = 1'b1;
         tick();
      end
   endtask

   // Returns how many bands differ from the model.
   task automatic scan_all(output int bad);
      logic [6:0] b, p;
      bad = 0;
      for (int a = 0; a < NB; a++) begin
         read_band(a, b, p);
         if (b !== 7'(mBar[a]) || p !== 7'(mPeak[a])) bad++;
      end
   endtask

   task automatic test_reset();
      int cyc, bad;
      bit es;
      Reset = 1'b1;
      repeat (3) tick();
      tests++;
      if (Busy !== 1'b1 || End !== 1'b0 || RdBar !== 7'd0 || RdPeak !== 7'd0) begin
         fails++;
         $display("FAIL reset_state: Busy=%b End=%b RdBar=%0d RdPeak=%0d, want 1 0 0 0",
                  Busy, End, RdBar, RdPeak);
      end
      Reset = 1'b0;
      measure_sweep(cyc, es);
      tests++;
      if (cyc != 32) begin
         fails++;
         $display("FAIL reset_sweep_len: busy %0d cycles, want 32", cyc);
      end
      tests++;
      if (es) begin
         fails++;
         $display("FAIL reset_sweep_end: End asserted during sweep, want never");
      end
      model_clear();
      scan_all(bad);
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_store_zero: %0d bands nonzero, want 0", bad);
      end
   endtask

   task automatic test_band5();
      bit ok;
      logic [6:0] b, p;
      int wantB[3] = '{40, 37, 36};
      int inV[3]   = '{40, 10, 36};
      for (int i = 0; i < 3; i++) begin
         do_update(5, inV[i], ok);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL band5_timing[%0d]: End/Busy off 4-cycle handshake", i);
         end
         read_band(5, b, p);
         tests++;
         if (b !== 7'(wantB[i]) || p !== 7'd40) begin
            fails++;
            $display("FAIL band5_value[%0d]: bar=%0d peak=%0d, want bar=%0d peak=40",
                     i, b, p, wantB[i]);
         end
      end
   endtask

   task automatic test_hold_fall();
      bit ok, allok;
      int bad;
      logic [6:0] b, p;
      allok = 1'b1; bad = 0;
      do_update(7, 20, ok);
      allok &= ok;
      for (int i = 1; i <= 13; i++) begin
         do_update(7, 0, ok);
         allok &= ok;
         read_band(7, b, p);
         if (b !== 7'(mBar[7]) || p !== 7'(mPeak[7])) bad++;
      end
      tests++;
      if (bad != 0 || !allok) begin
         fails++;
         $display("FAIL hold_sequence: %0d reads differ from model, handshake ok=%b", bad, allok);
      end
      tests++;
      if (b !== 7'd0 || p !== 7'd19) begin
         fails++;
         $display("FAIL hold_final: bar=%0d peak=%0d, want bar=0 peak=19", b, p);
      end
   endtask

   task automatic test_clamp();
      bit ok;
      logic [6:0] b, p;
      do_update(0, 120, ok);
      read_band(0, b, p);
      tests++;
      if (!ok || b !== 7'd96 || p !== 7'd96) begin
         fails++;
         $display("FAIL clamp: bar=%0d peak=%0d ok=%b, want 96 96 1", b, p, ok);
      end
   endtask

   task automatic test_start_ignored();
      int ends;
      logic [6:0] b, p;
      int bad;
      Start = 1'b1; Band = 6'd1; In = 7'd50; tick();
      Band = 6'd2; In = 7'd60; tick();
      Band = 6'd3; In = 7'd70; tick();
      Start = 1'b0;
      ends = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (End === 1'b1) ends++;
      end
      model_update(1, 50);
      tests++;
      if (ends != 1) begin
         fails++;
         $display("FAIL ignored_start_ends: %0d End pulses, want 1", ends);
      end
      bad = 0;
      for (int a = 1; a <= 3; a++) begin
         read_band(a, b, p);
         if (b !== 7'(mBar[a]) || p !== 7'(mPeak[a])) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL ignored_start_store: %0d of bands 1..3 wrong, want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] b, p;
      int bad;
      Band = 6'd10; In = 7'd30; Start = 1'b1; tick();       // cycle 1
      Start = 1'b0;
      tick(); tick(); tick();                                // cycle 4
      // Start/Clear during the End cycle must be ignored.
      Band = 6'd11; In = 7'd44; Start = 1'b1; Clear = 1'b1;
      tick();                                                // cycle 5
      Clear = 1'b0;
      tests++;
      if (Busy !== 1'b0 || End !== 1'b0) begin
         fails++;
         $display("FAIL b2b_cycle5: Busy=%b End=%b, want 0 0", Busy, End);
      end
      Band = 6'd12; In = 7'd55;                              // accepted here
      tick();
      Start = 1'b0;
      tick(); tick(); tick();
      tests++;
      if (End !== 1'b1) begin
         fails++;
         $display("FAIL b2b_second_end: End=%b at +4, want 1", End);
      end
      tick();
      model_update(10, 30);
      model_update(12, 55);
      bad = 0;
      for (int a = 10; a <= 12; a++) begin
         read_band(a, b, p);
         if (b !== 7'(mBar[a]) || p !== 7'(mPeak[a])) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL b2b_store: %0d of bands 10..12 wrong, want 0", bad);
      end
   endtask

   task automatic test_read_during_wr();
      int oldB;
      oldB = mBar[20];
      Band = 6'd20; In = 7'd70; Start = 1'b1; tick();        // cycle 1
      Start = 1'b0;
      tick(); tick();                                        // cycle 3 = WR
      RdAddr = 6'd20;
      tick();                                                // cycle 4
      model_update(20, 70);
      tests++;
      if (RdBar !== 7'(oldB) || End !== 1'b1) begin
         fails++;
         $display("FAIL rd_on_wr_old: RdBar=%0d End=%b, want %0d 1", RdBar, End, oldB);
      end
      tick();
      tests++;
      if (RdBar !== 7'(mBar[20]) || RdPeak !== 7'(mPeak[20])) begin
         fails++;
         $display("FAIL rd_after_wr_new: RdBar=%0d RdPeak=%0d, want %0d %0d",
                  RdBar, RdPeak, mBar[20], mPeak[20]);
      end
   endtask

   task automatic test_bad_band();
      bit ok;
      int bad;
      do_update(40, 50, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL bad_band_handshake: End/Busy off 4-cycle handshake");
      end
      scan_all(bad);
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL bad_band_store: %0d bands changed, want 0", bad);
      end
   endtask

   task automatic test_random();
      bit ok;
      int hsBad, rdBad, bad, bnd, val;
      logic [6:0] b, p;
      hsBad = 0; rdBad = 0;
      for (int i = 0; i < 120; i++) begin
         bnd = $urandom_range(0, 35);
         val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 96);
         do_update(bnd, val, ok);
         if (!ok) hsBad++;
         if ($urandom_range(0, 2) == 0) begin
            bnd = $urandom_range(0, NB - 1);
            read_band(bnd, b, p);
            if (b !== 7'(mBar[bnd]) || p !== 7'(mPeak[bnd])) rdBad++;
         end
      end
      tests++;
      if (hsBad != 0 || rdBad != 0) begin
         fails++;
         $display("FAIL random_updates: %0d handshake errors, %0d read errors, want 0 0",
                  hsBad, rdBad);
      end
      scan_all(bad);
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL random_final_store: %0d bands differ, want 0", bad);
      end
   endtask

   task automatic test_clear_start();
      int cyc, bad;
      bit es;
      Clear = 1'b1; Start = 1'b1; Band = 6'd4; In = 7'd90;
      tick();
      Clear = 1'b0; Start = 1'b0;
      measure_sweep(cyc, es);
      tests++;
      if (cyc != 32 || es) begin
         fails++;
         $display("FAIL clear_sweep: busy %0d cycles end_seen=%b, want 32 0", cyc, es);
      end
      model_clear();
      scan_all(bad);
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL clear_store: %0d bands nonzero, want 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, bad;
      bit ok, es;
      do_update(3, 90, ok);
      Band = 6'd3; In = 7'd10; Start = 1'b1; tick();
      Start = 1'b0;
      tick();                                                // mid-update
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      measure_sweep(cyc, es);
      tests++;
      if (cyc != 32 || es) begin
         fails++;
         $display("FAIL reset_mid_update: busy %0d cycles end_seen=%b, want 32 0", cyc, es);
      end
      model_clear();
      scan_all(bad);
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_mid_store: %0d bands nonzero, want 0", bad);
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      Reset = 1'b1; Start = 1'b0; Clear = 1'b0;
      In = '0; Band = '0; RdAddr = '0;
      model_clear();
      test_reset();
      test_band5();
      test_hold_fall();
      test_clamp();
      test_start_ignored();
      test_back_to_back();
      test_read_during_wr();
      test_bad_band();
      test_random();
      test_clear_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
